// File: rtl/muldiv_seq_ctrl.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply resolved in IDLE; divide stays iterative.
module muldiv_seq_ctrl #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] result_rd
);
  // state | meaning
  // IDLE  | wait for start; div-by-zero / overflow (and fast multiply) resolved here
  // CALC  | one iteration per cycle while cnt counts down to zero
  // FIXUP | sign correction and result word selection
  // DONE  | one-cycle writeback strobe
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [2:0]          op;
  logic [REG_AW-1:0]   rd_q;
  logic                neg_res;

  logic                is_div, rs1_sgn, rs2_sgn, a_neg, b_neg;
  logic                div_zero, div_ovf, special, fast_mul, accept;
  logic [XLEN-1:0]     a_mag, b_mag, special_val, fast_val, fix_val;
  logic [XLEN:0]       mul_sum, div_sh;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   acc_step, prod_fix;

  assign is_div   = funct3[2];
  assign rs1_sgn  = is_div ? ~funct3[0] : (funct3 != 3'b011);
  assign rs2_sgn  = is_div ? ~funct3[0] : ~funct3[1];
  assign a_neg    = rs1_sgn & rs1_val[XLEN-1];
  assign b_neg    = rs2_sgn & rs2_val[XLEN-1];
  assign a_mag    = a_neg ? -rs1_val : rs1_val;
  assign b_mag    = b_neg ? -rs2_val : rs2_val;
  assign div_zero = is_div & (rs2_val == '0);
  assign div_ovf  = is_div & ~funct3[0] & (rs1_val == MIN_NEG) & (&rs2_val);
  assign special  = div_zero | div_ovf;
  assign accept   = (state == S_IDLE) & start & ~flush;

  always_comb begin
    special_val = '0;
    if (funct3[1]) special_val = div_zero ? rs1_val : '0;
    else           special_val = div_zero ? '1 : MIN_NEG;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  // Low 2*XLEN bits of the sign-extended product equal the signed 33x33 result.
  assign fast_a    = {{XLEN{a_neg}}, rs1_val};
  assign fast_b    = {{XLEN{b_neg}}, rs2_val};
  assign fast_prod = fast_a * fast_b;
  assign fast_mul  = ~is_div;
  assign fast_val  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul  = 1'b0;
  assign fast_val  = '0;
`endif

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opb};
  assign div_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, opb};
  assign div_diff = div_sh[XLEN-1:0] - opb;
  assign acc_step = op[2] ? (div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                                    : {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0})
                          : {mul_sum, acc[XLEN-1:1]};
  assign prod_fix = neg_res ? -acc : acc;

  always_comb begin
    fix_val = '0;
    if (!op[2])     fix_val = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (!op[1]) fix_val = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    else            fix_val = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start) state_nxt = (special || fast_mul) ? S_DONE : S_CALC;
        S_CALC:  if (cnt == '0) state_nxt = S_FIXUP;
        S_FIXUP: state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall        = ((state == S_IDLE) & start) | (state == S_CALC) | (state == S_FIXUP);
    busy         = (state != S_IDLE);
    result_valid = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      op        <= '0;
      rd_q      <= '0;
      neg_res   <= 1'b0;
      result    <= '0;
      result_rd <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op      <= funct3;
          rd_q    <= rd_in;
          neg_res <= (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (special || fast_mul) begin
            result    <= special ? special_val : fast_val;
            result_rd <= rd_in;
          end else begin
            cnt <= CW'(XLEN-1);
            opb <= is_div ? b_mag : a_mag;
            acc <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        S_FIXUP: if (!flush) begin
          result    <= fix_val;
          result_rd <= rd_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: directed vector table, flush/reset sequences and random ops
// checked against an arithmetic reference model.
module tb_muldiv_seq_ctrl;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .result_rd(result_rd)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, sbu, p;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    sbu = ub;
    r = '0;
    case (f3)
      3'b000: begin p = sa * sb;  r = p[31:0];  end
      3'b001: begin p = sa * sb;  r = p[63:32]; end
      3'b010: begin p = sa * sbu; r = p[63:32]; end
      3'b011: begin up = ua * ub; r = up[63:32]; end
      3'b100: if (b == 0) r = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
              else r = ia / ib;
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 0) r = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
              else r = ia % ib;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return FAST ? 1 : 34;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
    int cyc, stall_low;
    bit seen;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
    #1;
    check({tag, "_stall_accept"}, stall, 1);
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
    cyc = 1; stall_low = 0; seen = 1'b0;
    while (cyc <= 60) begin
      if (result_valid) begin seen = 1'b1; break; end
      if (!stall) stall_low++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_valid_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_rd"}, result_rd, rd);
      check({tag, "_stall_done"}, stall, 0);
      check({tag, "_stall_low_cycles"}, stall_low, 0);
      @(posedge clk); #1;
      check({tag, "_valid_one_cycle"}, result_valid, 0);
      check({tag, "_result_hold"}, result, exp_res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    vecs[0]  = '{3'b000, 32'd4,          32'd4,          5'd26, 32'd16,         34};
    vecs[1]  = '{3'b110, 32'd20,         32'd8,          5'd3,  32'd4,          34};
    vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  34};
    vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFF,  34};
    vecs[4]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'd1,          34};
    vecs[5]  = '{3'b101, 32'd7,          32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    vecs[6]  = '{3'b110, 32'd7,          32'd0,          5'd8,  32'd7,          1};
    vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
    vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
    vecs[9]  = '{3'b001, 32'hFFFF_F000,  32'd4,          5'd11, 32'hFFFF_FFFF,  34};
    vecs[10] = '{3'b011, 32'hFFFF_F000,  32'd4,          5'd12, 32'd3,          34};
    vecs[11] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 32'hFFFF_FFFF,  34};

    rstn = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_rd", result_rd, 0);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      int lat;
      lat = (FAST && !vecs[i].f3[2]) ? 1 : vecs[i].lat;
      do_op($sformatf("tbl%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, lat);
    end

    // Flush of a divide in its tenth cycle.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_stall", stall, 0);
    check("flush_valid", result_valid, 0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    check("flush_no_valid", seen, 0);
    do_op("post_flush_mul", 3'b000, 32'd123, 32'd456, 5'd17, 32'd56088, exp_lat(3'b000, 32'd123, 32'd456));

    // Flush together with start in IDLE is ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd2;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);
    check("flush_start_valid", result_valid, 0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b111; rs1_val = 32'd99; rs2_val = 32'd3; rd_in = 5'd21;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_stall", stall, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_rd", result_rd, 0);
    @(negedge clk) rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    check("midrst_no_valid", seen, 0);
    do_op("post_rst_mul", 3'b000, 32'd4, 32'd4, 5'd26, 32'd16, exp_lat(3'b000, 32'd4, 32'd4));

    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom);
      rd = 5'($urandom);
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($signed(8'($urandom))); b = 32'($signed(8'($urandom))); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_op($sformatf("rnd%0d", n), f3, a, b, rd, ref_model(f3, a, b), exp_lat(f3, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the CPU's single-cycle ALU.
- Accepts one operation from the execute stage and stalls the pipeline while it iterates.
- Returns the result and destination register for register-bank writeback.
- Uses a radix-2 shift-add multiplier and a restoring divider: one bit per cycle.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
REG_AW, 5, destination register index width.

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  request from execute stage (opcode 0110011, funct7 0000001)
funct3  input  3  M-ext op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A
rs2_val  input  XLEN  operand B
rd_in  input  REG_AW  destination register
flush  input  1  abort in-flight op, no writeback
stall  output  1  hold PC/fetch/decode
busy  output  1  operation in flight
result_valid  output  1  one-cycle writeback strobe
result  output  XLEN  writeback data
result_rd  output  REG_AW  writeback register

Behaviour:
- Reset values (async, rstn low): state=IDLE; busy=0; result_valid=0; result=0; result_rd=0; counter=0.
- Reset mid-operation discards the op; no result_valid follows.
- FSM states:
  - IDLE: start=1 latches funct3, rd_in, operand magnitudes and sign flags.
    - Div-by-zero or signed overflow -> DONE.
    - Otherwise -> CALC, counter=XLEN-1.
  - CALC: one iteration per cycle; counter decrements; at counter==0 -> FIXUP.
  - FIXUP: applies sign correction, selects the result word, loads result/result_rd -> DONE.
  - DONE: result_valid=1 for exactly one cycle -> IDLE.
- Latency, counted from the accepting edge to the result_valid cycle:
  - Normal op: XLEN+2 cycles (34).
  - Special case: 1 cycle.
- stall = (state==IDLE & start) | state==CALC | state==FIXUP.
  - stall is low in DONE so the pipeline retires the instruction with the writeback.
- busy = state!=IDLE.
- start while busy is ignored; the pipeline guarantees this cannot occur while stalled.
- Multiply:
  - 2*XLEN product accumulator over operand magnitudes.
  - Signed ops take the absolute value of the signed operands; result is negated in FIXUP if the signs differ.
  - MULHSU treats rs2 as unsigned.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide: restoring division over magnitudes.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no CALC:
  - rs2==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF returns 0x80000000; REM in the same case returns 0.
  - Multiply ops have no special cases.
- flush: any state -> IDLE next edge; result_valid stays 0.
  - flush together with start in IDLE: start is ignored.
- result/result_rd hold their last value outside DONE.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined:
  - Multiply ops use a single-cycle 33x33 signed product computed in IDLE and go straight to DONE (latency 1).
  - stall is asserted only in the accepting cycle.
  - Divide ops are unchanged.
- Undefined:
  - All ops use the iterative path as above.
  - No hardware multiplier is inferred.

Test Plan:
- MUL rs1=4, rs2=4, rd=26 -> result_valid exactly 34 cycles after accept; result=16, result_rd=26; stall high for the 33 cycles before result_valid.
- REM rs1=20, rs2=8 -> result=4. DIV rs1=-7, rs2=2 -> result=-3. REM rs1=-7, rs2=2 -> result=-1. REMU 0xFFFFFFF9 % 2 -> result=1.
- DIVU 7/0 -> result=0xFFFFFFFF after 1 cycle; REM 7%0 -> result=7. DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000; REM of the same operands -> result=0.
- MULH rs1=0xFFFFF000 (-4096), rs2=4 -> result=0xFFFFFFFF. MULHU with the same operands -> result=0x00000003. MULHSU rs1=-1, rs2=0xFFFFFFFF -> result=0xFFFFFFFF.
- Start DIV, assert flush on cycle 10 -> IDLE next cycle, no result_valid, stall low. A new MUL issued afterwards completes normally.
- Drop rstn for 1 cycle mid-CALC -> all outputs return to 0 immediately; no result_valid. With MULDIV_FAST_MUL_EN defined: MUL 4*4 -> result_valid 1 cycle after accept, result=16.
